// File: rtl/bus_arbiter.sv
// Round-robin arbiter and bus mux for the shared req/gnt transfer bus.
// It issues a delayed one-cycle grant pulse and holds the bus for one transfer per grant.
module bus_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned GNT_DELAY = 2,
  parameter int unsigned TIMEOUT   = 15,
  localparam int unsigned IW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  output logic [N_MASTERS-1:0]          m_gnt,
  input  logic [N_MASTERS-1:0]          m_trans,
  input  logic [N_MASTERS-1:0]          m_write,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic                          s_trans,
  output logic                          s_write,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic [IW-1:0]                 owner,
  output logic                          busy,
  output logic                          timeout_err
);

  typedef enum logic [1:0] {StIdle, StDelay, StGrant, StOwn} state_e;

  localparam logic [3:0] DlyLast = 4'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);
  localparam logic [7:0] ToLast  = 8'(TIMEOUT - 1);

  state_e                 state_q;
  logic [N_MASTERS-1:0]   m_gnt_q;
  logic                   timeout_err_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          ptr_q;
  logic [3:0]             dly_cnt_q;
  logic [7:0]             to_cnt_q;
  logic                   seen_q;

  logic [IW-1:0]          winner;
  logic [IW-1:0]          ptr_nxt;
  logic                   own;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    logic [IW-1:0] cand;
    logic          found;
    winner = ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      cand = IW'((32'(ptr_q) + i) % N_MASTERS);
      if (!found && m_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign ptr_nxt = (owner_q == IW'(N_MASTERS - 1)) ? '0 : owner_q + 1'b1;
  assign own     = (state_q == StOwn);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      m_gnt_q       <= '0;
      timeout_err_q <= 1'b0;
      owner_q       <= '0;
      ptr_q         <= '0;
      dly_cnt_q     <= '0;
      to_cnt_q      <= '0;
      seen_q        <= 1'b0;
    end else begin
      m_gnt_q       <= '0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|m_req) begin
            owner_q   <= winner;
            dly_cnt_q <= '0;
            state_q   <= (GNT_DELAY > 0) ? StDelay : StGrant;
          end
        end
        StDelay: begin
          if (!m_req[owner_q]) begin
            state_q <= StIdle;
          end else if (dly_cnt_q == DlyLast) begin
            state_q <= StGrant;
          end else begin
            dly_cnt_q <= dly_cnt_q + 4'd1;
          end
        end
        StGrant: begin
          // The grant pulse is registered, so it lines up with the first owned cycle.
          m_gnt_q[owner_q] <= 1'b1;
          to_cnt_q         <= '0;
          seen_q           <= 1'b0;
          state_q          <= StOwn;
        end
        StOwn: begin
          if (s_trans && s_ready) begin
            state_q <= StIdle;
            ptr_q   <= ptr_nxt;
          end else if (seen_q || m_trans[owner_q]) begin
            seen_q <= 1'b1;
          end else if (to_cnt_q == ToLast) begin
            timeout_err_q <= 1'b1;
            state_q       <= StIdle;
            ptr_q         <= ptr_nxt;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    m_ready = '0;
    if (own) begin
      m_ready[owner_q] = s_ready;
    end
  end

  assign s_trans     = own & m_trans[owner_q];
  assign s_write     = own & m_write[owner_q];
  assign s_addr      = own ? m_addr[32'(owner_q) * ADDR_W +: ADDR_W] : '0;
  assign s_wdata     = own ? m_wdata[32'(owner_q) * DATA_W +: DATA_W] : '0;
  assign m_rdata     = s_rdata;
  assign m_gnt       = m_gnt_q;
  assign owner       = owner_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Multi-master arbiter and bus mux for the shared req/gnt + trans/write/addr/wdata/rdata/ready bus. It replaces the bench-level grant generator, arbitrates up to N_MASTERS master BFMs round-robin, and issues a one-cycle grant pulse after a programmable delay. It routes the winning master's transfer to the single slave and holds ownership until the transfer completes. It sits between the master_bfm instances and slave_bfm in tb_top, and later in RTL top.

Parameters:
N_MASTERS, 2, number of requesting masters (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width
GNT_DELAY, 2, idle cycles between winner selection and gnt pulse (0..15)
TIMEOUT, 15, max cycles after gnt for owner to raise trans (1..255)

Ports:
clk  in  1  bus clock; all logic on posedge
rst  in  1  synchronous, active-high reset
m_req  in  N_MASTERS  per-master bus request
m_gnt  out  N_MASTERS  one-hot grant pulse, registered
m_trans  in  N_MASTERS  per-master transfer valid
m_write  in  N_MASTERS  per-master write(1)/read(0)
m_addr  in  N_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  N_MASTERS*DATA_W  packed write data, same packing
m_rdata  out  DATA_W  read data, broadcast to all masters (= s_rdata)
m_ready  out  N_MASTERS  per-master ready; only the owner's bit can be 1
s_trans  out  1  transfer valid to slave
s_write  out  1  write to slave
s_addr  out  ADDR_W  address to slave
s_wdata  out  DATA_W  write data to slave
s_rdata  in  DATA_W  read data from slave
s_ready  in  1  slave ready; transfer completes on s_trans && s_ready
owner  out  max(1,$clog2(N_MASTERS))  index of current/last owner
busy  out  1  1 in any state other than IDLE
timeout_err  out  1  one-cycle pulse when an owner times out

Behaviour:
- States: IDLE, DELAY, GRANT, OWN.
- Reset (rst=1 at posedge): state=IDLE, m_gnt=0, timeout_err=0, owner=0, priority pointer=0, counters=0. Combinational outputs follow: s_trans=0, s_write=0, s_addr=0, s_wdata=0, m_ready=0, busy=0. Reset mid-transfer aborts the transfer immediately with no completion.
- IDLE: if m_req!=0, the winner is the first set bit scanning from the pointer upward with wrap. Latch owner. Go to DELAY if GNT_DELAY>0, else GRANT.
- DELAY: count GNT_DELAY cycles, then GRANT. If m_req[owner] drops during DELAY, return to IDLE with no gnt; the pointer is unchanged.
- GRANT: m_gnt[owner]=1 for exactly this one cycle; next state is OWN. For a req first sampled in IDLE at edge T, gnt is high in the cycle after edge T+1+GNT_DELAY (GNT_DELAY=2 gives 3 cycles).
- OWN: the bus is muxed combinationally from the owner. s_trans=m_trans[owner], s_write, s_addr and s_wdata likewise, and m_ready[owner]=s_ready. Completion is s_trans && s_ready at a posedge; on completion go to IDLE with pointer=(owner+1) mod N_MASTERS. Completion may occur in the first OWN cycle.
- Timeout: a counter runs in OWN only while the owner has not yet asserted trans since gnt. If it reaches TIMEOUT, timeout_err pulses for 1 cycle, state goes to IDLE and the pointer advances. Once trans has been seen, there is no timeout: wait for ready indefinitely.
- Outside OWN: all s_* outputs and m_ready are 0. Non-owner m_trans and m_req are ignored.
- One transfer per grant. A master wanting back-to-back transfers keeps req high and re-arbitrates. Minimum gap from completion to the next gnt is GNT_DELAY+2 cycles.
- N_MASTERS=1: always wins; pointer stays 0.

Test Plan:
- Single master 0, GNT_DELAY=2: req rises at edge T -> m_gnt[0] pulse in cycle T+3, exactly 1 cycle. Write addr=0x10, wdata=0xA5A5_0001, s_ready=1 on trans -> slave sees the same values; busy falls the cycle after completion.
- Masters 0 and 1 request together and hold req for 4 transfers -> grant order 0,1,0,1 and owner matches each; no overlapping s_trans.
- Owner 1 gets gnt but never raises trans, TIMEOUT=15 -> timeout_err pulses 15 cycles after gnt, then master 0 (pending) is granted next.
- Master 0 drops req during DELAY -> no m_gnt, return to IDLE; a later req from master 1 is granted normally.
- Read with s_ready delayed 5 cycles, s_rdata=0xDEAD_BEEF -> m_ready[owner] high only on the completion cycle; m_rdata=0xDEAD_BEEF; other m_ready bits are 0.
- rst asserted during OWN with s_trans=1 -> next cycle s_trans=0, busy=0, owner=0, pointer=0; the first post-reset grant goes to the lowest requesting index.
